// File: rtl/cp_pkg.sv
// cp_pkg: shared constants, state encoding and helpers for the column-parity sequencer
package cp_pkg;

   localparam int ROWS_DEF = 5;
   localparam int Y_W = 3;

   typedef logic [1:0] state_t;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic logic is_last_row(input logic [Y_W-1:0] y, input int rows);
      return y == Y_W'(rows - 1);
   endfunction

endpackage

// File: rtl/cp_parity_acc.sv
// cp_parity_acc: ROWS-bit parity register that can load, xor-fold or hold a row word
module cp_parity_acc
   import cp_pkg::*;
#(
   parameter int ROWS = ROWS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            fold,
   input  logic [ROWS-1:0] d,
   output logic [ROWS-1:0] q
);

   // the first row of a slice replaces the old parity, later rows fold into it
   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
      else if (fold)
         q <= q ^ d;
   end

endmodule

// File: rtl/cp_sequencer.sv
// cp_sequencer: walks every slice, xor-folds its row words and writes the column parity
module cp_sequencer
   import cp_pkg::*;
#(
   parameter int N    = 6,
   parameter int ROWS = ROWS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [N+Y_W-1:0]  mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [ROWS-1:0]   mem_rd_data,
   output logic              par_wr_en,
   output logic [N-1:0]      par_wr_addr,
   output logic [ROWS-1:0]   par_wr_data,
   input  logic              par_wr_ready
);

   state_t          state;
   logic [N-1:0]    z;
   logic [Y_W-1:0]  y;
   logic [ROWS-1:0] acc;
   logic            rd_take;
   logic            last_row;
   logic            last_slice;

   assign rd_take    = state == S_READ && mem_rd_valid;
   assign last_row   = is_last_row(y, ROWS);
   assign last_slice = &z;

   // pass control: read rows of slice z, write its parity, advance until z is all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         z     <= '0;
         y     <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state <= S_READ;
               z     <= '0;
               y     <= '0;
            end
            S_READ: if (mem_rd_valid) begin
               if (last_row)
                  state <= S_WRITE;
               else
                  y <= y + 1'b1;
            end
            S_WRITE: if (par_wr_ready) begin
               if (last_slice) begin
                  state <= S_DONE;
               end else begin
                  state <= S_READ;
                  z     <= z + 1'b1;
                  y     <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               z     <= '0;
               y     <= '0;
            end
         endcase
      end
   end

   cp_parity_acc #(.ROWS(ROWS)) u_acc (
      .clk   (clk),
      .reset (reset),
      .load  (rd_take && y == '0),
      .fold  (rd_take && y != '0),
      .d     (mem_rd_data),
      .q     (acc)
   );

   assign busy        = state == S_READ || state == S_WRITE;
   assign done        = state == S_DONE;
   assign mem_rd_en   = state == S_READ;
   assign mem_rd_addr = {z, y};
   assign par_wr_en   = state == S_WRITE;
   assign par_wr_addr = z;
   assign par_wr_data = par_wr_en ? acc : '0;

endmodule

// File: tb/tb_cp_sequencer.sv
// tb_cp_sequencer: directed passes checked every cycle against a slice/parity model
module tb_cp_sequencer;
   import cp_pkg::*;

   localparam int N  = 6;
   localparam int NS = 2;
   localparam int R  = 5;
   localparam int SL = 1 << N;

   logic clk = 0, reset = 1, start = 0, s_start = 0;
   logic busy, done, rd_en, rd_valid, wr_en, wr_ready;
   logic [N+2:0] rd_addr;
   logic [R-1:0] rd_data, wr_data;
   logic [N-1:0] wr_addr;
   logic s_busy, s_done, s_rd_en, s_wr_en;
   logic [NS+2:0] s_rd_addr;
   logic [NS-1:0] s_wr_addr;
   logic [R-1:0] s_wr_data;

   int ncmp = 0, nfail = 0, edges = 0;
   int mode = 0, dly = 0, stall_z = -1, t0 = 0, done_cyc = 0;
   int rz = 0, ry = 0, wz = 0, nwr = 0, ndone = 0, wcnt = 0, scnt = 0;
   int s_t0 = 0, s_wz = 0;
   bit active = 0, s_active = 0, pulsed = 0;

   always #5 clk = ~clk;

   cp_sequencer #(.N(N), .ROWS(R)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_valid(rd_valid), .mem_rd_data(rd_data),
      .par_wr_en(wr_en), .par_wr_addr(wr_addr), .par_wr_data(wr_data), .par_wr_ready(wr_ready)
   );

   cp_sequencer #(.N(NS), .ROWS(R)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
      .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_valid(s_rd_en), .mem_rd_data(5'h1f),
      .par_wr_en(s_wr_en), .par_wr_addr(s_wr_addr), .par_wr_data(s_wr_data), .par_wr_ready(1'b1)
   );

   function automatic logic [R-1:0] row(input int m, input int zz, input int yy);
      return m == 0 ? 5'h1f : m == 1 ? R'(yy + 1) : R'(zz * 7 + yy * 13 + 3);
   endfunction

   function automatic logic [R-1:0] par(input int m, input int zz);
      logic [R-1:0] x = '0;
      for (int k = 0; k < R; k++) x ^= row(m, zz, k);
      return x;
   endfunction

   function automatic int done_at(input int n, input int d, input int extra);
      return (1 << n) * (R * (d + 1) + 1) + extra + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // memory models: waits of dly cycles per row, optional write stall, noise outside handshakes
   assign rd_data  = row(mode, int'(rd_addr[N+2:3]), int'(rd_addr[2:0]));
   assign rd_valid = rd_en ? (wcnt >= dly) : edges[0];
   assign wr_ready = wr_en ? !(int'(wr_addr) == stall_z && scnt < 3) : edges[1];

   // cycle counter and wait/stall counters of the memory models
   always @(posedge clk) begin
      edges <= edges + 1;
      wcnt  <= (rd_en && !rd_valid) ? wcnt + 1 : 0;
      scnt  <= !busy ? 0 : (wr_en && !wr_ready) ? scnt + 1 : scnt;
   end

   // main compare process: timing, address order and parity against the model
   always @(negedge clk) begin
      int cyc;
      if (active) begin
         cyc = edges - t0;
         chk("done", done, cyc == done_cyc);
         chk("busy", busy, cyc >= 1 && cyc < done_cyc);
         chk("rd_wr_exclusive", rd_en & wr_en, 0);
         if (rd_en) begin
            chk("rd_addr", rd_addr, {rz[N-1:0], ry[2:0]});
            if (rd_valid) begin
               ry++;
               if (ry == R) begin ry = 0; rz++; end
            end
         end
         if (wr_en) begin
            chk("wr_addr", wr_addr, wz[N-1:0]);
            chk("wr_data", wr_data, par(mode, wz));
            if (wr_ready) begin wz++; nwr++; end
         end
         if (done) ndone++;
      end
   end

   // compare process for the N=2 instance (zero-wait, all-ones rows)
   always @(negedge clk) begin
      int cyc;
      if (s_active) begin
         cyc = edges - s_t0;
         chk("s_done", s_done, cyc == done_at(NS, 0, 0));
         chk("s_busy", s_busy, cyc >= 1 && cyc < done_at(NS, 0, 0));
         chk("s_rd_wr_exclusive", s_rd_en & s_wr_en, 0);
         if (s_rd_en) chk("s_rd_y_range", s_rd_addr[2:0] < 3'(R), 1);
         if (s_wr_en) begin
            chk("s_wr_addr", s_wr_addr, s_wz[NS-1:0]);
            chk("s_wr_data", s_wr_data, 5'h1f);
            s_wz++;
         end
      end
   end

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
   endtask

   task automatic run(input int m, input int d, input int sz, input int pz, input int abort_z);
      @(negedge clk);
      mode = m; dly = d; stall_z = sz; pulsed = 0;
      rz = 0; ry = 0; wz = 0; nwr = 0; ndone = 0;
      done_cyc = done_at(N, d, sz >= 0 ? 3 : 0);
      t0 = edges; active = 1; start = 1;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < done_cyc + 4; i++) begin
         @(negedge clk);
         start = 0;
         if (pz >= 0 && !pulsed && rd_en && int'(rd_addr[N+2:3]) == pz) begin
            start = 1; pulsed = 1;
         end
         if (abort_z >= 0 && rd_en && int'(rd_addr[N+2:3]) == abort_z) begin
            active = 0; reset = 1;
            @(negedge clk);
            check_idle_zero("abort");
            reset = 0;
            repeat (10) begin
               @(negedge clk);
               chk("no_done_after_abort", done, 0);
            end
            return;
         end
      end
      active = 0;
      chk("write_count", nwr, SL);
      chk("done_count", ndone, 1);
   endtask

   initial begin
      reset = 1;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      chk("s_reset_busy", s_busy, 0);
      chk("s_reset_wr_en", s_wr_en, 0);
      reset = 0;
      chk("pin_par_ones", par(0, 5), 5'h1f);
      chk("pin_par_seq", par(1, 33), 5'h01);
      chk("pin_par_hash", par(2, 0), 5'd19);
      chk("pin_done_zero_wait", done_at(6, 0, 0), 385);
      chk("pin_done_wait2", done_at(6, 2, 0), 1025);
      chk("pin_done_n2", done_at(2, 0, 0), 25);
      run(0, 0, -1, -1, -1);
      run(1, 0, -1, -1, -1);
      run(2, 2, -1, -1, -1);
      run(2, 0, 10, -1, -1);
      run(0, 0, -1, 7, -1);
      run(1, 0, -1, -1, 20);
      run(2, 0, -1, -1, -1);
      @(negedge clk);
      s_wz = 0; s_t0 = edges; s_active = 1; s_start = 1;
      @(negedge clk);
      s_start = 0;
      repeat (30) @(negedge clk);
      s_active = 0;
      chk("s_write_count", s_wz, 4);
      chk("s_busy_after", s_busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
